// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI memory subsystem: master state encoding,
// op-bit values and serial frame length arithmetic.
package spi_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SHIFT,
      WAIT_ACK,
      RECV,
      DONE
   } state_t;

   localparam logic OP_WR = 1'b1;
   localparam logic OP_RD = 1'b0;

   // Bits on the wire for one frame: op bit, address, then data on writes only.
   function automatic int frame_bits(input int addr_w, input int data_w, input logic op);
      return 1 + addr_w + ((op == OP_WR) ? data_w : 0);
   endfunction

   function automatic int sel_width(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/spi_mem_slave.sv
// One SPI memory slave: LSB-first frame receiver, DEPTH x DATA_W storage,
// write acknowledge and read data return on miso.
module spi_mem_slave
   import spi_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic cs_n,
   input  logic mosi,
   output logic miso,
   output logic ready,
   output logic op_done
);

   localparam int FRAME_W = frame_bits(ADDR_W, DATA_W, OP_WR);
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  TX_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  cnt;
   logic              op_q;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-2:0] data_sr;
   logic [DATA_W-1:0] tx_sr;
   logic [CNT_W-1:0]  tx_cnt;
   logic              tx_on;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign in_range = ({1'b0, addr_sr} < DEPTH_V);
   assign idx      = addr_sr[IDX_W-1:0];
   assign miso     = ~cs_n & tx_on & tx_sr[0];

   // Frame receiver; deselect drops any partial frame without touching memory.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         op_q    <= 1'b0;
         addr_sr <= '0;
         data_sr <= '0;
         ready   <= 1'b0;
         op_done <= 1'b0;
      end else if (cs_n) begin
         cnt     <= '0;
         ready   <= 1'b0;
         op_done <= 1'b0;
      end else begin
         ready   <= 1'b0;
         op_done <= 1'b0;
         if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
         if (cnt == '0) begin
            op_q <= mosi;
         end else if (cnt <= ADDR_LAST) begin
            addr_sr <= {mosi, addr_sr[ADDR_W-1:1]};
         end else if (op_q == OP_WR && cnt < DATA_LAST) begin
            data_sr <= {mosi, data_sr[DATA_W-2:1]};
         end
         if (cnt == ADDR_LAST && op_q == OP_RD) ready <= 1'b1;
         if (cnt == DATA_LAST && op_q == OP_WR) op_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!cs_n && cnt == DATA_LAST && op_q == OP_WR && in_range) begin
         mem[idx] <= {mosi, data_sr};
      end
   end

   // Read return: load during the ready cycle, then DATA_W bits LSB first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sr  <= '0;
         tx_cnt <= '0;
         tx_on  <= 1'b0;
      end else if (cs_n) begin
         tx_cnt <= '0;
         tx_on  <= 1'b0;
      end else if (ready) begin
         tx_sr  <= in_range ? mem[idx] : '0;
         tx_cnt <= '0;
         tx_on  <= 1'b1;
      end else if (tx_on) begin
         tx_sr <= tx_sr >> 1;
         if (tx_cnt == TX_LAST) tx_on <= 1'b0;
         else                   tx_cnt <= tx_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_mem_sys.sv
// SPI memory subsystem top: request front end, range checks, SPI master FSM
// with ack timeout, and NUM_SLAVES memory slaves on a shared mosi.
module spi_mem_sys
   import spi_mem_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_SLAVES = 2,
   parameter int TIMEOUT    = 64,
   parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [SEL_W-1:0]  req_sel,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] rdata
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, so a held request waits until the prior done.

   localparam int FRAME_W = frame_bits(ADDR_W, DATA_W, OP_WR);
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam int WAIT_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  LAST_WR   = CNT_W'(frame_bits(ADDR_W, DATA_W, OP_WR) - 1);
   localparam logic [CNT_W-1:0]  LAST_RD   = CNT_W'(frame_bits(ADDR_W, DATA_W, OP_RD) - 1);
   localparam logic [CNT_W-1:0]  RECV_LAST = CNT_W'(DATA_W - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
   localparam logic [SEL_W:0]    NSL_V     = (SEL_W + 1)'(NUM_SLAVES);

   state_t              state, next_state;
   logic                wr_q;
   logic [SEL_W-1:0]    sel_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [FRAME_W-1:0]  frame_q;
   logic                err_q;
   logic [CNT_W-1:0]    bit_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [DATA_W-2:0]   rx_q;

   logic [NUM_SLAVES-1:0] cs_n;
   logic                  mosi;
   logic [NUM_SLAVES-1:0] slave_miso;
   logic [NUM_SLAVES-1:0] slave_ready;
   logic [NUM_SLAVES-1:0] slave_op_done;
   logic                  miso_any;
   logic                  ready_any;
   logic                  op_done_any;

   logic range_err, shift_last, ack, timed_out, recv_last;

   assign miso_any    = |slave_miso;
   assign ready_any   = |slave_ready;
   assign op_done_any = |slave_op_done;

   assign range_err  = ({1'b0, sel_q} >= NSL_V) || ({1'b0, addr_q} >= DEPTH_V);
   assign shift_last = (bit_cnt == (wr_q ? LAST_WR : LAST_RD));
   assign ack        = wr_q ? op_done_any : ready_any;
   assign timed_out  = !ack && (wait_cnt == WAIT_LAST);
   assign recv_last  = (bit_cnt == RECV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (req_valid) next_state = CHECK;
         CHECK:    next_state = range_err ? DONE : SHIFT;
         SHIFT:    if (shift_last) next_state = WAIT_ACK;
         WAIT_ACK: begin
            if (ack)            next_state = wr_q ? DONE : RECV;
            else if (timed_out) next_state = DONE;
         end
         RECV:     if (recv_last) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      mosi      = 1'b0;
      cs_n      = '1;
      case (state)
         IDLE:    req_ready = 1'b1;
         SHIFT:   mosi = frame_q[0];
         DONE: begin
            done  = 1'b1;
            error = err_q;
         end
         default: ;
      endcase
      if (state == SHIFT || state == WAIT_ACK || state == RECV) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) cs_n[i] = 1'b0;
         end
      end
   end

   // Datapath; frame is {data, addr, op} so shifting right emits LSB first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q     <= 1'b0;
         sel_q    <= '0;
         addr_q   <= '0;
         frame_q  <= '0;
         err_q    <= 1'b0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
         rx_q     <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q    <= req_wr;
                  sel_q   <= req_sel;
                  addr_q  <= req_addr;
                  frame_q <= {req_wdata, req_addr, req_wr};
                  err_q   <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            CHECK: begin
               err_q    <= range_err;
               bit_cnt  <= '0;
               wait_cnt <= '0;
            end
            SHIFT: begin
               frame_q  <= frame_q >> 1;
               bit_cnt  <= shift_last ? '0 : bit_cnt + 1'b1;
               wait_cnt <= '0;
            end
            WAIT_ACK: begin
               bit_cnt  <= '0;
               wait_cnt <= wait_cnt + 1'b1;
               if (timed_out) err_q <= 1'b1;
            end
            RECV: begin
               rx_q    <= {miso_any, rx_q[DATA_W-2:1]};
               bit_cnt <= bit_cnt + 1'b1;
               if (recv_last) rdata <= {miso_any, rx_q};
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
      spi_mem_slave #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_slave (
         .clk     (clk),
         .rst     (rst),
         .cs_n    (cs_n[g]),
         .mosi    (mosi),
         .miso    (slave_miso[g]),
         .ready   (slave_ready[g]),
         .op_done (slave_op_done[g])
      );
   end

endmodule

// File: tb/tb_spi_mem_sys.sv
// Bench for spi_mem_sys: driver tasks issue requests, a memory reference model
// predicts each completion into exp_q, and a negedge monitor checks every done.
module tb_spi_mem_sys;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int DEPTH   = 16;
   localparam int NSL     = 2;
   localparam int TIMEOUT = 64;
   localparam int SEL_W   = 1;
   localparam int EXP_W   = 1 + DATA_W + 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_wr = 1'b0;
   logic [SEL_W-1:0]  req_sel = '0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              done;
   logic              error;
   logic [DATA_W-1:0] rdata;

   spi_mem_sys dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_sel   (req_sel),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .error     (error),
      .rdata     (rdata)
   );

   // ---------------- clock / reset / bookkeeping ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_viol = 0;
   int last_done_cyc = -1;
   logic ready_chk = 1'b0;

   logic [EXP_W-1:0]  exp_q[$];
   int                acc_q[$];

   // Reference model: plain per-slave arrays and the last good read value.
   logic [DATA_W-1:0] mem_m [NSL][DEPTH];
   logic [DATA_W-1:0] last_rd;

   function automatic void check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < NSL; s++)
         for (int a = 0; a < DEPTH; a++) mem_m[s][a] = '0;
      last_rd = '0;
   endfunction

   function automatic void model_push(input logic wr, input int sel, input int addr,
                                      input logic [DATA_W-1:0] wd, input logic to);
      logic err;
      int   lat;
      if (sel >= NSL || addr >= DEPTH) begin
         err = 1'b1;
         lat = 2;
      end else if (to) begin
         err = 1'b1;
         lat = 2 + 1 + ADDR_W + (wr ? DATA_W : 0) + TIMEOUT;
      end else begin
         err = 1'b0;
         lat = wr ? (1 + 1 + ADDR_W + DATA_W + 1 + 1) : (1 + 1 + ADDR_W + 1 + DATA_W + 1);
         if (wr) mem_m[sel][addr] = wd;
         else    last_rd = mem_m[sel][addr];
      end
      exp_q.push_back({err, last_rd, 8'(lat)});
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      int a;
      if (rst) begin
         ready_chk = 1'b0;
      end else begin
         if (ready_chk) begin
            check("ready_after_done", int'(req_ready), 1);
            ready_chk = 1'b0;
         end
         if (done) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: actual=done required=no_done (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("error", int'(error), int'(e[EXP_W-1]));
               check("rdata", int'(rdata), int'(e[EXP_W-2:8]));
               check("latency", cyc - a + 1, int'(e[7:0]));
            end
            last_done_cyc = cyc;
            ready_chk = 1'b1;
         end
         if (acc_q.size() > 0 && req_ready) busy_viol++;
         if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept();
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (req_ready) return;
      end
      check("accept_timeout", 0, 1);
   endtask

   task automatic drive(input logic wr, input int sel, input int addr, input int wd);
      req_valid = 1'b1;
      req_wr    = wr;
      req_sel   = SEL_W'(sel);
      req_addr  = ADDR_W'(addr);
      req_wdata = DATA_W'(wd);
   endtask

   task automatic send(input logic wr, input int sel, input int addr, input int wd, input logic to);
      @(posedge clk); #1;
      drive(wr, sel, addr, wd);
      model_push(wr, sel, addr, DATA_W'(wd), to);
      wait_accept();
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 600; t++) begin
         if (exp_q.size() == 0) return;
         @(negedge clk);
      end
      check("completion_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, int'(req_ready), 1);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_error"}, int'(error), 0);
      check({tag, "_rdata"}, int'(rdata), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int c2;
      logic [NSL-1:0] cs_low;
      model_clear();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Write then read back on slave 0
      send(1'b1, 0, 8'h03, 8'hA5, 1'b0);
      send(1'b0, 0, 8'h03, 0, 1'b0);
      // Slaves hold independent contents
      send(1'b1, 1, 8'h03, 8'h3C, 1'b0);
      send(1'b0, 0, 8'h03, 0, 1'b0);
      send(1'b0, 1, 8'h03, 0, 1'b0);
      wait_idle();

      // Out-of-range address: quick error, no chip select
      send(1'b0, 0, 8'h10, 0, 1'b0);
      cs_low = '0;
      repeat (3) begin
         @(negedge clk);
         cs_low = cs_low | ~dut.cs_n;
      end
      check("range_cs_n_idle", int'(cs_low), 0);
      send(1'b1, 1, 8'hFF, 8'h55, 1'b0);
      wait_idle();

      // Missing acknowledge aborts after TIMEOUT
      force dut.ready_any = 1'b0;
      force dut.op_done_any = 1'b0;
      send(1'b0, 1, 8'h03, 0, 1'b1);
      wait_idle();
      release dut.ready_any;
      release dut.op_done_any;
      send(1'b0, 1, 8'h03, 0, 1'b0);
      wait_idle();

      // Held request: second write waits for the first done
      @(posedge clk); #1;
      drive(1'b1, 0, 8'h07, 8'h11);
      model_push(1'b1, 0, 8'h07, 8'h11, 1'b0);
      wait_accept();
      @(posedge clk); #1;
      drive(1'b1, 0, 8'h08, 8'h22);
      model_push(1'b1, 0, 8'h08, 8'h22, 1'b0);
      check("busy_ready_low", int'(req_ready), 0);
      wait_accept();
      c2 = cyc;
      check("b2b_accept_cycle", c2, last_done_cyc + 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      send(1'b0, 0, 8'h07, 0, 1'b0);
      send(1'b0, 0, 8'h08, 0, 1'b0);
      wait_idle();

      // Reset during a write's shift phase
      @(posedge clk); #1;
      drive(1'b1, 0, 8'h05, 8'h77);
      wait_accept();
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      acc_q.delete();
      model_clear();
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      send(1'b0, 0, 8'h05, 0, 1'b0);
      send(1'b0, 1, 8'h03, 0, 1'b0);
      wait_idle();

      // Randomized traffic, mostly in range
      for (int i = 0; i < 60; i++) begin
         int a;
         a = ($urandom_range(0, 4) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH - 1);
         send(1'($urandom_range(0, 1)), $urandom_range(0, NSL - 1), a, $urandom_range(0, 255), 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      end
      for (int s = 0; s < NSL; s++)
         for (int a = 0; a < DEPTH; a++) send(1'b0, s, a, 0, 1'b0);
      wait_idle();

      repeat (5) @(negedge clk);
      check("busy_ready_violations", busy_viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
